// File: rtl/clock_pkg.sv
// clock_pkg: shared time-digit widths, limits and increment helper for the seconds/minutes/hours stages
package clock_pkg;
  localparam int TIME_W  = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  typedef logic [TIME_W-1:0] time_digit_t;
  function automatic time_digit_t digit_inc(input time_digit_t v, input int max);
    return (int'(v) >= max) ? '0 : v + time_digit_t'(1);
  endfunction
endpackage

// File: rtl/seconds_counter_prescaler.sv
// tick_prescaler: divide-by-DIV counter giving a one-cycle wrap tick and a registered first-half square wave
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic half
);
  localparam int W = (DIV < 2) ? 1 : $clog2(DIV);
  if (DIV < 2) begin : g_bad_div
    $error("tick_prescaler: DIV must be at least 2");
  end
  logic [W-1:0] r_cnt;
  logic         r_half;
  logic         w_wrap;
  logic [W-1:0] w_next;
  assign w_wrap = r_cnt == W'(DIV - 1);
  assign w_next = w_wrap ? '0 : r_cnt + W'(1);
  assign tick   = w_wrap;
  assign half   = r_half;
  // count the period; half only rises on a wrap so reset and clear never produce a spurious edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else begin
      r_cnt  <= w_next;
      r_half <= w_wrap ? 1'b1 : (w_next == W'(DIV / 2)) ? 1'b0 : r_half;
    end
endmodule

// File: rtl/seconds_counter.sv
// seconds_counter: 0..59 seconds register driven by tick_prescaler; SECONDS_FAST_SIM_EN forces a divide-by-4 period
module seconds_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       zero_sec,
  output logic [5:0] seconds,
  output logic       seconds_clk,
  output logic       tick
);
`ifdef SECONDS_FAST_SIM_EN
  localparam int DIV = 4;
`else
  localparam int DIV = CLK_HZ;
`endif
  logic        w_tick;
  logic        w_half;
  logic        r_pend;
  time_digit_t r_sec;
  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (zero_sec),
    .tick (w_tick),
    .half (w_half)
  );
  // delay the update one edge past the seconds_clk rise so the minutes stage samples the old value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sec  <= '0;
      r_pend <= 1'b0;
    end else if (zero_sec) begin
      r_sec  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_tick;
      if (r_pend && !hold) r_sec <= digit_inc(r_sec, SEC_MAX);
    end
  assign seconds     = r_sec;
  assign seconds_clk = w_half;
  assign tick        = w_tick;
endmodule

// File: tb/tb_seconds_counter.sv
// tb_seconds_counter: scoreboard bench for seconds_counter at CLK_HZ=10
module tb_seconds_counter;
`ifdef SECONDS_FAST_SIM_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 10;
`endif
  typedef struct packed {
    logic [5:0] sec;
    logic       sclk;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic       zero_sec = 1'b0;
  logic [5:0] seconds;
  logic       seconds_clk;
  logic       tick;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cnt = 0;
  int   m_sec = 0;
  bit   m_armed = 0;
  bit   m_pend = 0;
  exp_t q[$];
  exp_t e;

  seconds_counter #(.CLK_HZ(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .zero_sec   (zero_sec),
    .seconds    (seconds),
    .seconds_clk(seconds_clk),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0;
    m_sec = 0;
    m_armed = 0;
    m_pend = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (zero_sec) begin
      model_reset();
    end else begin
      if (m_pend && !hold) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
      m_pend = (m_cnt == DIV - 1);
      if (m_pend) begin
        m_cnt = 0;
        m_armed = 1;
      end else m_cnt++;
    end
    q.push_back('{sec: 6'(m_sec), sclk: m_armed && (m_cnt < DIV / 2), tick: m_cnt == DIV - 1});
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (seconds !== 6'd0) begin n_err++; $display("FAIL reset_seconds got %0d want 0", seconds); end
    n_cmp++; if (seconds_clk !== 1'b0) begin n_err++; $display("FAIL reset_sclk got %b want 0", seconds_clk); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", tick); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_second();
    int rose_at = -1, one_at = -1, tick_bad = 0;
    logic prev = 1'b0;
    for (int i = 1; i <= DIV + 2; i++) begin
      cyc();
      e = q.pop_front();
      n_cmp++;
      if ({seconds, seconds_clk, tick} !== e) begin
        n_err++;
        $display("FAIL sb_first cyc %0d got sec=%0d sclk=%b tick=%b want sec=%0d sclk=%b tick=%b", i, seconds, seconds_clk, tick, e.sec, e.sclk, e.tick);
      end
      if (seconds_clk && !prev && rose_at < 0) rose_at = i;
      if (seconds == 6'd1 && one_at < 0) one_at = i;
      if (tick !== (i == DIV - 1)) tick_bad++;
      prev = seconds_clk;
    end
    n_cmp++; if (rose_at != DIV) begin n_err++; $display("FAIL first_rise cycle got %0d want %0d", rose_at, DIV); end
    n_cmp++; if (one_at != DIV + 1) begin n_err++; $display("FAIL first_update cycle got %0d want %0d", one_at, DIV + 1); end
    n_cmp++; if (tick_bad != 0) begin n_err++; $display("FAIL first_tick_only_cycle bad cycles got %0d want 0", tick_bad); end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    logic prev_sclk = seconds_clk, prev_rose = 1'b0;
    logic [5:0] prev_sec = seconds;
    for (int i = 0; i < 600; i++) begin
      cyc();
      e = q.pop_front();
      n_cmp++;
      if ({seconds, seconds_clk, tick} !== e) begin
        n_err++;
        $display("FAIL sb_wrap cyc %0d got sec=%0d sclk=%b tick=%b want sec=%0d sclk=%b tick=%b", i, seconds, seconds_clk, tick, e.sec, e.sclk, e.tick);
      end
      if (prev_sec == 6'd59 && seconds == 6'd0) begin
        wraps++;
        n_cmp++;
        if (!prev_rose) begin n_err++; $display("FAIL wrap_sampled_59 rise before wrap got %b want 1", prev_rose); end
      end
      prev_rose = seconds_clk && !prev_sclk;
      prev_sclk = seconds_clk;
      prev_sec = seconds;
    end
    n_cmp++; if (wraps != 1) begin n_err++; $display("FAIL wrap_count got %0d want 1", wraps); end
  endtask

  task automatic test_hold();
    int guard = 0, rises = 0, moved = 0;
    logic prev;
    while (seconds != 6'd5 && guard < 800) begin
      cyc();
      e = q.pop_front();
      n_cmp++;
      if ({seconds, seconds_clk, tick} !== e) begin
        n_err++;
        $display("FAIL sb_hold_seek got sec=%0d sclk=%b tick=%b want sec=%0d sclk=%b tick=%b", seconds, seconds_clk, tick, e.sec, e.sclk, e.tick);
      end
      guard++;
    end
    n_cmp++; if (seconds != 6'd5) begin n_err++; $display("FAIL hold_seek timeout got sec=%0d want 5", seconds); end
    hold = 1'b1;
    prev = seconds_clk;
    for (int i = 0; i < 30; i++) begin
      cyc();
      e = q.pop_front();
      n_cmp++;
      if ({seconds, seconds_clk, tick} !== e) begin
        n_err++;
        $display("FAIL sb_hold cyc %0d got sec=%0d sclk=%b tick=%b want sec=%0d sclk=%b tick=%b", i, seconds, seconds_clk, tick, e.sec, e.sclk, e.tick);
      end
      if (seconds_clk && !prev) rises++;
      if (seconds != 6'd5) moved++;
      prev = seconds_clk;
    end
    hold = 1'b0;
    n_cmp++; if (moved != 0) begin n_err++; $display("FAIL hold_frozen cycles changed got %0d want 0", moved); end
    n_cmp++; if (rises != 30 / DIV) begin n_err++; $display("FAIL hold_sclk_rises got %0d want %0d", rises, 30 / DIV); end
  endtask

  task automatic test_zero_sec();
    int guard = 0, first = -1;
    while (!(seconds == 6'd37 && m_cnt == 6) && guard < 600) begin
      cyc();
      e = q.pop_front();
      n_cmp++;
      if ({seconds, seconds_clk, tick} !== e) begin
        n_err++;
        $display("FAIL sb_zero_seek got sec=%0d sclk=%b tick=%b want sec=%0d sclk=%b tick=%b", seconds, seconds_clk, tick, e.sec, e.sclk, e.tick);
      end
      guard++;
    end
    n_cmp++; if (seconds != 6'd37) begin n_err++; $display("FAIL zero_seek timeout got sec=%0d want 37", seconds); end
    zero_sec = 1'b1;
    hold = 1'b1;
    cyc();
    zero_sec = 1'b0;
    hold = 1'b0;
    e = q.pop_front();
    n_cmp++;
    if (seconds !== 6'd0 || tick !== 1'b0 || {seconds, seconds_clk, tick} !== e) begin
      n_err++;
      $display("FAIL zero_clear got sec=%0d sclk=%b tick=%b want sec=0 sclk=%b tick=0", seconds, seconds_clk, tick, e.sclk);
    end
    for (int k = 1; k <= DIV + 2; k++) begin
      cyc();
      e = q.pop_front();
      n_cmp++;
      if ({seconds, seconds_clk, tick} !== e) begin
        n_err++;
        $display("FAIL sb_zero cyc %0d got sec=%0d sclk=%b tick=%b want sec=%0d sclk=%b tick=%b", k, seconds, seconds_clk, tick, e.sec, e.sclk, e.tick);
      end
      if (tick && first < 0) first = k;
    end
    n_cmp++; if (first != DIV - 1) begin n_err++; $display("FAIL zero_next_tick cycle got %0d want %0d", first, DIV - 1); end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (m_cnt != 8 && guard < 20) begin
      cyc();
      e = q.pop_front();
      n_cmp++;
      if ({seconds, seconds_clk, tick} !== e) begin
        n_err++;
        $display("FAIL sb_rst_seek got sec=%0d sclk=%b tick=%b want sec=%0d sclk=%b tick=%b", seconds, seconds_clk, tick, e.sec, e.sclk, e.tick);
      end
      guard++;
    end
    n_cmp++; if (seconds == 6'd0) begin n_err++; $display("FAIL rst_precondition seconds got 0 want nonzero"); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (seconds !== 6'd0) begin n_err++; $display("FAIL rst_async_seconds got %0d want 0", seconds); end
    n_cmp++; if (seconds_clk !== 1'b0) begin n_err++; $display("FAIL rst_async_sclk got %b want 0", seconds_clk); end
    @(posedge clk);
    #1;
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_no_tick got %b want 0", tick); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= DIV + 1; i++) begin
      cyc();
      e = q.pop_front();
      n_cmp++;
      if ({seconds, seconds_clk, tick} !== e) begin
        n_err++;
        $display("FAIL sb_rst cyc %0d got sec=%0d sclk=%b tick=%b want sec=%0d sclk=%b tick=%b", i, seconds, seconds_clk, tick, e.sec, e.sclk, e.tick);
      end
    end
    n_cmp++; if (seconds !== 6'd1) begin n_err++; $display("FAIL rst_first_update got %0d want 1", seconds); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      hold = ($urandom_range(0, 3) == 0);
      zero_sec = ($urandom_range(0, 59) == 0);
      cyc();
      e = q.pop_front();
      n_cmp++;
      if ({seconds, seconds_clk, tick} !== e) begin
        n_err++;
        $display("FAIL sb_random cyc %0d got sec=%0d sclk=%b tick=%b want sec=%0d sclk=%b tick=%b", i, seconds, seconds_clk, tick, e.sec, e.sclk, e.tick);
      end
    end
    hold = 1'b0;
    zero_sec = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_second();
    test_wrap();
    test_hold();
    test_zero_sec();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
